fwd_hazard_ctrl: RTL and testbench

- Parametrised next-generation forwarding unit for the 5-stage pipeline.
- Generalises EX-stage operand forwarding to NUM_SRC source operands and REG_AW-bit register addresses.
- Adds load-use stall detection and a scoreboard/countdown FSM for one multi-cycle (MUL/DIV) unit, including its result forwarding and write-back arbitration.
- Sits between the ID/EX pipeline registers and the hazard/flush control of IF/ID.

---
 rtl/fwd_hazard_pkg.sv | 23 ++
 rtl/fwd_sel_lane.sv | 34 +++
 rtl/fwd_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_pkg.sv
// Shared types for the forwarding / hazard controller.
package fwd_hazard_pkg;

   // Forward-select encoding seen by the EX-stage operand muxes
   typedef enum logic [1:0] {
      FW_RF    = 2'b00,
      FW_MEMWB = 2'b01,
      FW_EXMEM = 2'b10,
      FW_MC    = 2'b11
   } fw_sel_t;

   // Multi-cycle unit scoreboard states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      WB   = 2'b10
   } mc_state_t;

   // Countdown width covers MC_LAT up to 15
   localparam int unsigned MC_CNT_W    = 4;
   localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/fwd_sel_lane.sv
// Per-operand priority forward selector: EX/MEM > MC result > MEM/WB > regfile.
module fwd_sel_lane
   import fwd_hazard_pkg::*;
#(
   parameter int unsigned REG_AW = 5
) (
   input  logic [REG_AW-1:0] src_i,
   input  logic [REG_AW-1:0] exmem_rd_i,
   input  logic              exmem_regwr_i,
   input  logic              mc_wb_i,
   input  logic [REG_AW-1:0] mc_rd_i,
   input  logic [REG_AW-1:0] memwb_rd_i,
   input  logic              memwb_regwr_i,
   output logic [1:0]        fw_o
);

   fw_sel_t sel;

   // Register 0 is hard-wired, so a zero source never forwards
   always_comb begin
      sel = FW_RF;
      if (src_i != '0) begin
         if (exmem_regwr_i && (src_i == exmem_rd_i)) begin
            sel = FW_EXMEM;
         end else if (mc_wb_i && (src_i == mc_rd_i)) begin
            sel = FW_MC;
         end else if (memwb_regwr_i && (src_i == memwb_rd_i)) begin
            sel = FW_MEMWB;
         end
      end
      fw_o = sel;
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding, load-use stall and multi-cycle unit scoreboard.
// Optional stall-cycle counter enabled by FWD_HAZARD_STALL_CNT_EN.
module fwd_hazard_ctrl
   import fwd_hazard_pkg::*;
#(
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned MC_LAT  = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic [NUM_SRC*REG_AW-1:0] idex_src_i,
   input  logic [REG_AW-1:0]         idex_rd_i,
   input  logic                      idex_memrd_i,
   input  logic [NUM_SRC*REG_AW-1:0] ifid_src_i,
   input  logic [REG_AW-1:0]         ifid_rd_i,
   input  logic                      ifid_regwr_i,
   input  logic                      ifid_is_mc_i,
   input  logic                      mc_issue_i,
   input  logic [REG_AW-1:0]         exmem_rd_i,
   input  logic                      exmem_regwr_i,
   input  logic [REG_AW-1:0]         memwb_rd_i,
   input  logic                      memwb_regwr_i,
   output logic [NUM_SRC*2-1:0]      fw_o,
   output logic                      stall_o,
   output logic                      mc_wb_o,
   output logic [REG_AW-1:0]         mc_rd_o,
   output logic                      mc_busy_o,
   output logic                      mc_err_o
`ifdef FWD_HAZARD_STALL_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0]    stall_cnt_o
`endif
);

   mc_state_t             state_q, state_d;
   logic [MC_CNT_W-1:0]   cnt_q, cnt_d;
   logic [REG_AW-1:0]     mc_rd_q, mc_rd_d;
   logic                  err_q, err_d;
   logic                  mc_wb_c;
   logic                  busy_c;
   logic                  load_use_c, raw_hit_c, mc_struct_c;
   logic [NUM_SRC*2-1:0]  lane_fw;

   // Scoreboard state register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mc_rd_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mc_rd_q <= mc_rd_d;
         err_q   <= err_d;
      end
   end

   // Countdown FSM; write-back yields the regfile port to the pipeline
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mc_rd_d = mc_rd_q;
      err_d   = err_q;
      mc_wb_c = 1'b0;
      if (mc_issue_i && (state_q != IDLE)) begin
         err_d = 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (mc_issue_i) begin
               state_d = BUSY;
               cnt_d   = MC_CNT_W'(MC_LAT - 1);
               mc_rd_d = idex_rd_i;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - MC_CNT_W'(1);
            if (cnt_q == MC_CNT_W'(1)) begin
               state_d = WB;
            end
         end
         WB: begin
            if (!memwb_regwr_i) begin
               mc_wb_c = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Per-operand forward selectors
   for (genvar k = 0; k < NUM_SRC; k++) begin : g_lane
      fwd_sel_lane #(.REG_AW(REG_AW)) u_lane (
         .src_i         (idex_src_i[k*REG_AW +: REG_AW]),
         .exmem_rd_i    (exmem_rd_i),
         .exmem_regwr_i (exmem_regwr_i),
         .mc_wb_i       (mc_wb_c),
         .mc_rd_i       (mc_rd_q),
         .memwb_rd_i    (memwb_rd_i),
         .memwb_regwr_i (memwb_regwr_i),
         .fw_o          (lane_fw[k*2 +: 2])
      );
   end

   // Hazard detection against EX load and the pending multi-cycle result
   always_comb begin
      load_use_c  = 1'b0;
      raw_hit_c   = 1'b0;
      busy_c      = (state_q != IDLE);
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (idex_memrd_i && (idex_rd_i != '0) &&
             (ifid_src_i[k*REG_AW +: REG_AW] == idex_rd_i)) begin
            load_use_c = 1'b1;
         end
         if ((mc_rd_q != '0) && (ifid_src_i[k*REG_AW +: REG_AW] == mc_rd_q)) begin
            raw_hit_c = 1'b1;
         end
      end
      mc_struct_c = busy_c && (ifid_is_mc_i ||
                    (ifid_regwr_i && (mc_rd_q != '0) && (ifid_rd_i == mc_rd_q)));
   end

   // Forward/stall outputs are forced quiet while reset is asserted
   assign fw_o      = rst_n_i ? lane_fw : '0;
   assign stall_o   = rst_n_i && (load_use_c || (busy_c && raw_hit_c && !mc_wb_c) || mc_struct_c);
   assign mc_wb_o   = mc_wb_c;
   assign mc_rd_o   = mc_rd_q;
   assign mc_busy_o = busy_c;
   assign mc_err_o  = err_q;

`ifdef FWD_HAZARD_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_cnt_q;

   // Saturating count of stalled cycles
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stall_cnt_q <= '0;
      end else if (stall_o && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl with an expected-value queue.
module tb_fwd_hazard_ctrl;

   localparam int unsigned REG_AW  = 5;
   localparam int unsigned NUM_SRC = 2;

   logic                      clk_i = 1'b0;
   logic                      rst_n_i;
   logic [NUM_SRC*REG_AW-1:0] idex_src_i, ifid_src_i;
   logic [REG_AW-1:0]         idex_rd_i, ifid_rd_i, exmem_rd_i, memwb_rd_i;
   logic                      idex_memrd_i, ifid_regwr_i, ifid_is_mc_i, mc_issue_i;
   logic                      exmem_regwr_i, memwb_regwr_i;
   logic [NUM_SRC*2-1:0]      fw_o;
   logic                      stall_o, mc_wb_o, mc_busy_o, mc_err_o;
   logic [REG_AW-1:0]         mc_rd_o;
`ifdef FWD_HAZARD_STALL_CNT_EN
   logic [15:0]               stall_cnt_o;
`endif

   typedef struct packed {
      logic [3:0] fw;
      logic       stall;
      logic       wb;
      logic [4:0] rd;
      logic       busy;
      logic       err;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   fwd_hazard_ctrl #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MC_LAT(4)) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .idex_src_i    (idex_src_i),
      .idex_rd_i     (idex_rd_i),
      .idex_memrd_i  (idex_memrd_i),
      .ifid_src_i    (ifid_src_i),
      .ifid_rd_i     (ifid_rd_i),
      .ifid_regwr_i  (ifid_regwr_i),
      .ifid_is_mc_i  (ifid_is_mc_i),
      .mc_issue_i    (mc_issue_i),
      .exmem_rd_i    (exmem_rd_i),
      .exmem_regwr_i (exmem_regwr_i),
      .memwb_rd_i    (memwb_rd_i),
      .memwb_regwr_i (memwb_regwr_i),
      .fw_o          (fw_o),
      .stall_o       (stall_o),
      .mc_wb_o       (mc_wb_o),
      .mc_rd_o       (mc_rd_o),
      .mc_busy_o     (mc_busy_o),
      .mc_err_o      (mc_err_o)
`ifdef FWD_HAZARD_STALL_CNT_EN
      ,
      .stall_cnt_o   (stall_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_in();
      idex_src_i = '0; ifid_src_i = '0;
      idex_rd_i = '0; ifid_rd_i = '0; exmem_rd_i = '0; memwb_rd_i = '0;
      idex_memrd_i = 1'b0; ifid_regwr_i = 1'b0; ifid_is_mc_i = 1'b0; mc_issue_i = 1'b0;
      exmem_regwr_i = 1'b0; memwb_regwr_i = 1'b0;
   endtask

   task automatic expect_(input logic [3:0] fw, input logic stall, input logic wb,
                          input logic [4:0] rd, input logic busy, input logic err);
      exp_t e;
      e.fw = fw; e.stall = stall; e.wb = wb; e.rd = rd; e.busy = busy; e.err = err;
      q.push_back(e);
   endtask

   // Compare current outputs against the oldest queued expectation
   task automatic check_now(input string tag);
      exp_t e;
      if (q.size() == 0) begin
         chk({tag, " queue"}, 16'd0, 16'd1);
      end else begin
         e = q.pop_front();
         chk({tag, " fw"},    16'(fw_o),      16'(e.fw));
         chk({tag, " stall"}, 16'(stall_o),   16'(e.stall));
         chk({tag, " wb"},    16'(mc_wb_o),   16'(e.wb));
         chk({tag, " rd"},    16'(mc_rd_o),   16'(e.rd));
         chk({tag, " busy"},  16'(mc_busy_o), 16'(e.busy));
         chk({tag, " err"},   16'(mc_err_o),  16'(e.err));
      end
   endtask

   task automatic check(input string tag);
      @(negedge clk_i);
      check_now(tag);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      // Reset with active match conditions: outputs must stay quiet
      rst_n_i = 1'b0;
      clear_in();
      exmem_regwr_i = 1'b1; exmem_rd_i = 5'd5; idex_src_i = {5'd0, 5'd5};
      idex_memrd_i = 1'b1; idex_rd_i = 5'd7; ifid_src_i = {5'd7, 5'd0};
      expect_(4'b0000, 0, 0, 5'd0, 0, 0);
      check("reset");
      #2;
      clear_in();
      rst_n_i = 1'b1;
      tick();

      // Forward priority
      exmem_regwr_i = 1'b1; exmem_rd_i = 5'd5; memwb_regwr_i = 1'b1; memwb_rd_i = 5'd5;
      idex_src_i = {5'd0, 5'd5};
      expect_(4'b0010, 0, 0, 5'd0, 0, 0); check("fw_exmem_wins"); tick();
      exmem_regwr_i = 1'b0;
      expect_(4'b0001, 0, 0, 5'd0, 0, 0); check("fw_memwb"); tick();
      exmem_regwr_i = 1'b1; memwb_rd_i = 5'd6; idex_src_i = {5'd5, 5'd6};
      expect_(4'b1001, 0, 0, 5'd0, 0, 0); check("fw_two_lanes"); tick();
      exmem_rd_i = 5'd0; memwb_rd_i = 5'd0; idex_src_i = '0;
      expect_(4'b0000, 0, 0, 5'd0, 0, 0); check("fw_reg0"); tick();
      clear_in();

      // Load-use stall
      idex_memrd_i = 1'b1; idex_rd_i = 5'd7; ifid_src_i = {5'd7, 5'd0};
      expect_(4'b0000, 1, 0, 5'd0, 0, 0); check("load_use"); tick();
      idex_memrd_i = 1'b0; idex_rd_i = 5'd0;
      expect_(4'b0000, 0, 0, 5'd0, 0, 0); check("load_use_clear"); tick();
      idex_memrd_i = 1'b1; idex_rd_i = 5'd0; ifid_src_i = '0;
      expect_(4'b0000, 0, 0, 5'd0, 0, 0); check("load_use_r0"); tick();
      clear_in();

      // MC op, RAW stall and result forwarding
      mc_issue_i = 1'b1; idex_rd_i = 5'd9; ifid_src_i = {5'd0, 5'd9};
      expect_(4'b0000, 0, 0, 5'd0, 0, 0); check("mc_c0"); tick();
      mc_issue_i = 1'b0; idex_rd_i = 5'd0;
      for (int c = 1; c <= 3; c++) begin
         expect_(4'b0000, 1, 0, 5'd9, 1, 0); check($sformatf("mc_c%0d", c)); tick();
      end
      idex_src_i = {5'd0, 5'd9};
      expect_(4'b0011, 0, 1, 5'd9, 1, 0); check("mc_c4_wb"); tick();
      expect_(4'b0000, 0, 0, 5'd9, 0, 0); check("mc_c5_idle"); tick();
      clear_in();

      // Write-back arbitration and structural/WAW stalls
      mc_issue_i = 1'b1; idex_rd_i = 5'd3;
      expect_(4'b0000, 0, 0, 5'd9, 0, 0); check("arb_c0"); tick();
      clear_in();
      expect_(4'b0000, 0, 0, 5'd3, 1, 0); check("arb_c1"); tick();
      ifid_is_mc_i = 1'b1;
      expect_(4'b0000, 1, 0, 5'd3, 1, 0); check("arb_c2_struct"); tick();
      ifid_is_mc_i = 1'b0; ifid_regwr_i = 1'b1; ifid_rd_i = 5'd3;
      expect_(4'b0000, 1, 0, 5'd3, 1, 0); check("arb_c3_waw"); tick();
      clear_in();
      memwb_regwr_i = 1'b1; memwb_rd_i = 5'd12;
      expect_(4'b0000, 0, 0, 5'd3, 1, 0); check("arb_c4_hold"); tick();
      expect_(4'b0000, 0, 0, 5'd3, 1, 0); check("arb_c5_hold"); tick();
      memwb_regwr_i = 1'b0; idex_src_i = {5'd0, 5'd3};
      expect_(4'b0011, 0, 1, 5'd3, 1, 0); check("arb_c6_wb"); tick();
      clear_in();
      expect_(4'b0000, 0, 0, 5'd3, 0, 0); check("arb_c7_idle"); tick();

      // Issue while busy, then reset mid-operation
      mc_issue_i = 1'b1; idex_rd_i = 5'd10;
      expect_(4'b0000, 0, 0, 5'd3, 0, 0); check("err_c0"); tick();
      idex_rd_i = 5'd11;
      expect_(4'b0000, 0, 0, 5'd10, 1, 0); check("err_c1_reissue"); tick();
      clear_in();
      expect_(4'b0000, 0, 0, 5'd10, 1, 1); check("err_c2"); tick();
      expect_(4'b0000, 0, 0, 5'd10, 1, 1); check("err_c3"); tick();
      expect_(4'b0000, 0, 1, 5'd10, 1, 1); check("err_c4_wb"); tick();
      expect_(4'b0000, 0, 0, 5'd10, 0, 1); check("err_c5_sticky"); tick();
      mc_issue_i = 1'b1; idex_rd_i = 5'd13;
      expect_(4'b0000, 0, 0, 5'd10, 0, 1); check("rst_c0"); tick();
      clear_in();
      ifid_src_i = {5'd0, 5'd13};
      expect_(4'b0000, 1, 0, 5'd13, 1, 1); check("rst_c1_busy");
      #2;
      rst_n_i = 1'b0;
      #1;
      expect_(4'b0000, 0, 0, 5'd0, 0, 0); check_now("rst_async");
      clear_in();
      tick();
      rst_n_i = 1'b1;
      tick();
      expect_(4'b0000, 0, 0, 5'd0, 0, 0); check("rst_after"); tick();

`ifdef FWD_HAZARD_STALL_CNT_EN
      // Stall counter and saturation
      idex_memrd_i = 1'b1; idex_rd_i = 5'd7; ifid_src_i = {5'd7, 5'd0};
      repeat (3) tick();
      clear_in();
      @(negedge clk_i);
      chk("stall_cnt_3", stall_cnt_o, 16'd3);
      idex_memrd_i = 1'b1; idex_rd_i = 5'd7; ifid_src_i = {5'd7, 5'd0};
      repeat (70000) tick();
      clear_in();
      @(negedge clk_i);
      chk("stall_cnt_sat", stall_cnt_o, 16'hFFFF);
`endif

      chk("queue_drained", 16'(q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
